// File: rtl/gate_unit_pkg.sv
// Shared constants for the debounced gate unit.
//   - Mode encodings selecting the reduction applied to the debounced switches.
//   - Edge counter width and saturation value.
package gate_unit_pkg;

  localparam logic [2:0] MODE_OR   = 3'd0;
  localparam logic [2:0] MODE_AND  = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_NAND = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  localparam int unsigned EDGE_CNT_W = 8;
  localparam logic [EDGE_CNT_W-1:0] EDGE_CNT_MAX = 8'd255;

endpackage

// File: rtl/sw_debounce.sv
// One-bit switch conditioner: 2-flop synchroniser followed by a stability
// counter. The stable output only follows the synchronised input once it has
// differed from stable for DB_CYCLES consecutive cycles.
// Ports:
//   clk      - clock
//   rst_n    - synchronous active-low reset, clears all state
//   sw_i     - raw asynchronous switch input
//   stable_o - debounced value (registered)
module sw_debounce #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_i,
  output logic stable_o
);

  localparam int unsigned CntW = $clog2(DB_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        // Held long enough: accept the new value and restart counting.
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/debounced_gate_unit.sv
// Debounced gate unit: each switch is synchronised and debounced, then a
// Mode-selected reduction (OR/AND/XOR/NOR/NAND/XNOR, else 0) over all
// debounced bits drives a registered LED.
// Optional feature macro: GATE_COUNT_EN enables a saturating counter of LED
// rising edges on Edge_Count; without it Edge_Count is tied to zero.
// Ports:
//   clk        - clock
//   rst_n      - synchronous active-low reset
//   Sw         - raw switch inputs (N_SW bits)
//   Mode       - gate function select (not debounced)
//   LED        - registered gate result
//   Sw_LED     - debounced switch vector
//   Edge_Count - LED rising-edge count (saturating) or 0
module debounced_gate_unit
  import gate_unit_pkg::*;
#(
  parameter int unsigned N_SW      = 2,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SW-1:0]       Sw,
  input  logic [2:0]            Mode,
  output logic                  LED,
  output logic [N_SW-1:0]       Sw_LED,
  output logic [EDGE_CNT_W-1:0] Edge_Count
);

  logic [N_SW-1:0] stable;
  logic            led_q, led_d;

  for (genvar i = 0; i < N_SW; i++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_sw_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_i    (Sw[i]),
      .stable_o(stable[i])
    );
  end

  // Debounced values are already registered inside each debouncer.
  assign Sw_LED = stable;

  always_comb begin
    led_d = 1'b0;
    case (Mode)
      MODE_OR:   led_d = |stable;
      MODE_AND:  led_d = &stable;
      MODE_XOR:  led_d = ^stable;
      MODE_NOR:  led_d = ~|stable;
      MODE_NAND: led_d = ~&stable;
      MODE_XNOR: led_d = ~^stable;
      default:   led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led_d;
    end
  end

  assign LED = led_q;

`ifdef GATE_COUNT_EN
  logic [EDGE_CNT_W-1:0] edge_cnt_q;

  // Counts on the same edge the LED register goes 0->1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
    end else if (led_d && !led_q && (edge_cnt_q != EDGE_CNT_MAX)) begin
      edge_cnt_q <= edge_cnt_q + EDGE_CNT_W'(1);
    end
  end

  assign Edge_Count = edge_cnt_q;
`else
  assign Edge_Count = '0;
`endif

endmodule

// File: tb/tb_debounced_gate_unit.sv
module tb_debounced_gate_unit;

  logic       clk;
  logic       rst_n;
  logic [1:0] sw;
  logic [2:0] mode;
  logic       led;
  logic [1:0] sw_led;
  logic [7:0] edge_count;

  int n_cmp;
  int n_fail;

  debounced_gate_unit #(
    .N_SW     (2),
    .DB_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Sw        (sw),
    .Mode      (mode),
    .LED       (led),
    .Sw_LED    (sw_led),
    .Edge_Count(edge_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [1:0] v);
    sw = v;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sw    = 2'b11;
    mode  = 3'd0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (led !== 1'b0) begin
      n_fail++; $display("FAIL reset_led got=%b exp=0", led);
    end
    n_cmp++;
    if (sw_led !== 2'b00) begin
      n_fail++; $display("FAIL reset_sw_led got=%b exp=00", sw_led);
    end
    n_cmp++;
    if (edge_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_edge_count got=%0d exp=0", edge_count);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_cmp++;
      if (sw_led !== ((e == 6) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("FAIL reset_release_e%0d got=%b exp=%b", e, sw_led,
                           (e == 6) ? 2'b11 : 2'b00);
      end
    end
  endtask

  task automatic test_latency();
    mode = 3'd0;
    settle(2'b00);
    sw = 2'b01;
    for (int e = 1; e <= 7; e++) begin
      tick();
      n_cmp++;
      if (sw_led !== ((e >= 6) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL latency_sw_led_e%0d got=%b exp=%b", e, sw_led,
                           (e >= 6) ? 2'b01 : 2'b00);
      end
      n_cmp++;
      if (led !== (e == 7)) begin
        n_fail++; $display("FAIL latency_led_e%0d got=%b exp=%b", e, led, (e == 7));
      end
    end
  endtask

  task automatic test_glitch();
    mode = 3'd0;
    settle(2'b00);
    sw = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    sw = 2'b00;
    for (int e = 0; e < 20; e++) begin
      tick();
      n_cmp++;
      if (sw_led !== 2'b00 || led !== 1'b0) begin
        n_fail++; $display("FAIL glitch_c%0d got sw_led=%b led=%b exp 00/0", e, sw_led, led);
      end
    end
  endtask

  task automatic test_mode_sweep();
    logic [7:0] exp_led;
    exp_led = 8'b0001_0101; // bit m = expected LED for Mode m with stable=10
    mode = 3'd3; // NOR of 10 = 0
    settle(2'b10);
    for (int m = 0; m < 8; m++) begin
      mode = 3'(m);
      tick();
      n_cmp++;
      if (led !== exp_led[m]) begin
        n_fail++; $display("FAIL mode_%0d_e1 got=%b exp=%b", m, led, exp_led[m]);
      end
      tick();
      n_cmp++;
      if (led !== exp_led[m]) begin
        n_fail++; $display("FAIL mode_%0d_e2 got=%b exp=%b", m, led, exp_led[m]);
      end
    end
  endtask

  task automatic test_simultaneous();
    mode = 3'd1;
    settle(2'b00);
    sw = 2'b11;
    for (int e = 1; e <= 7; e++) begin
      tick();
      n_cmp++;
      if (sw_led !== ((e >= 6) ? 2'b11 : 2'b00) || led !== (e == 7)) begin
        n_fail++; $display("FAIL simult_e%0d got sw_led=%b led=%b", e, sw_led, led);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    mode = 3'd0;
    settle(2'b00);
    sw = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (sw_led !== 2'b00) begin
      n_fail++; $display("FAIL midrst_during got=%b exp=00", sw_led);
    end
    for (int e = 1; e <= 6; e++) begin
      tick();
      n_cmp++;
      if (sw_led !== ((e == 6) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL midrst_e%0d got=%b exp=%b", e, sw_led,
                           (e == 6) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_edge_counter();
    int exp_cnt;
    mode  = 3'd0;
    sw    = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle(2'b00);
    for (int i = 1; i <= 300; i++) begin
      sw = 2'b01;
      for (int c = 0; c < 7; c++) tick();
      sw = 2'b00;
      for (int c = 0; c < 7; c++) tick();
`ifdef GATE_COUNT_EN
      exp_cnt = (i > 255) ? 255 : i;
`else
      exp_cnt = 0;
`endif
      n_cmp++;
      if (edge_count !== 8'(exp_cnt)) begin
        n_fail++; $display("FAIL edge_cnt_i%0d got=%0d exp=%0d", i, edge_count, exp_cnt);
      end
    end
    for (int c = 0; c < 20; c++) tick();
`ifdef GATE_COUNT_EN
    exp_cnt = 255;
`else
    exp_cnt = 0;
`endif
    n_cmp++;
    if (edge_count !== 8'(exp_cnt)) begin
      n_fail++; $display("FAIL edge_cnt_hold got=%0d exp=%0d", edge_count, exp_cnt);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    sw     = 2'b00;
    mode   = 3'd0;
    test_reset();
    test_latency();
    test_glitch();
    test_mode_sweep();
    test_simultaneous();
    test_reset_mid_debounce();
    test_edge_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debounced_gate_unit.md
DEBOUNCED_GATE_UNIT -- requirements
Module: debounced_gate_unit

Interface
REQ-001 Parameter N_SW SHALL be defined as: default 2, range 2..16, number of switch inputs.
REQ-002 Parameter DB_CYCLES SHALL be defined as: default 4, range 2..1023, consecutive-cycle stability threshold for debounce.
REQ-003 Port clk SHALL be: input, 1 bit, single clock for all state.
REQ-004 Port rst_n SHALL be: input, 1 bit, reset; synchronous, active-low.
REQ-005 Port Sw SHALL be: input, N_SW bits, raw asynchronous board switches.
REQ-006 Port Mode SHALL be: input, 3 bits, gate function select.
REQ-007 Port LED SHALL be: output, 1 bit, registered gate result over debounced switches.
REQ-008 Port Sw_LED SHALL be: output, N_SW bits, registered mirror of the debounced switch values.
REQ-009 Port Edge_Count SHALL be: output, 8 bits, count of LED rising edges (see Configuration).

Function
REQ-010 Each Sw bit SHALL pass through a 2-flop synchroniser before debounce.
REQ-011 Per bit, the debouncer SHALL hold a stable value and a counter, with counter width clog2(DB_CYCLES)+1.
- Synchronised value != stable: counter increments.
- Synchronised value == stable: counter clears to 0.
REQ-012 When the counter equals DB_CYCLES-1 and the synchronised value still differs, stable SHALL take the synchronised value and the counter SHALL clear on that same edge.
REQ-013 A pulse shorter than DB_CYCLES synchronised cycles SHALL never change stable.
REQ-014 Sw_LED SHALL equal the debounced stable vector, with no further delay.
REQ-015 LED SHALL register, each cycle, f(Mode, stable vector) reduced over all N_SW bits, with this encoding:
- 0 OR
- 1 AND
- 2 XOR
- 3 NOR
- 4 NAND
- 5 XNOR
- 6 and 7 constant 0
REQ-016 Latency from a clean Sw change to the LED update SHALL be exactly 2+DB_CYCLES+1 clock edges.
REQ-017 Latency from a Mode change to the LED update SHALL be exactly 1 edge; Mode SHALL NOT be debounced.
REQ-018 Switch bits SHALL debounce independently.
- Simultaneous qualifying changes on several bits SHALL update stable on the same edge.
REQ-019 LED SHALL have no combinational path from Sw or Mode.

Reset
REQ-020 While rst_n=0 at a clk edge, the following SHALL clear to 0:
- synchroniser flops
- stable values
- counters
- LED
- Sw_LED
- Edge_Count
REQ-021 Reset asserted mid-debounce SHALL discard the partial count.
- After release, debounce SHALL restart from stable=0.
REQ-022 Switches already high at reset release SHALL appear on Sw_LED exactly 2+DB_CYCLES edges after release.

Configuration
REQ-023 With GATE_COUNT_EN defined, Edge_Count SHALL increment on each cycle where LED goes 0->1.
- It SHALL saturate at 255.
- It SHALL clear only on reset.
REQ-024 Without GATE_COUNT_EN, Edge_Count SHALL be tied to 8'd0.
- The port SHALL remain present.
- No counter logic SHALL be synthesised.

Structure
REQ-025 Package gate_unit_pkg SHALL hold:
- the Mode encoding constants (MODE_OR..MODE_XNOR)
- the Edge_Count width and saturation constant
REQ-026 Sub-module sw_debounce SHALL implement one bit (synchroniser + counter + stable), parametrised by DB_CYCLES.
- It SHALL be instantiated N_SW times via generate.
REQ-027 Gate reduction, LED register and edge counter SHALL reside in debounced_gate_unit.

Verification (N_SW=2, DB_CYCLES=4)
REQ-028 Reset: hold rst_n=0 for 3 cycles with Sw=2'b11 -> LED=0, Sw_LED=2'b00, Edge_Count=0; after release, Sw_LED=2'b11 at edge 6.
REQ-029 Latency: Mode=0, Sw 2'b00->2'b01 held -> Sw_LED=2'b01 at edge 6, LED=1 at edge 7, not earlier.
REQ-030 Glitch: Sw[0] high for 3 cycles then low -> Sw_LED and LED never change for 20 cycles.
REQ-031 Mode sweep: Sw=2'b10 stable, Mode 0..7 one per 2 cycles -> LED 1,0,1,0,1,0,0,0, each 1 edge after its Mode change.
REQ-032 Counter: with GATE_COUNT_EN, toggle Sw[0] (Mode=0) for 300 LED rising edges -> Edge_Count=255 and holds; without the macro -> Edge_Count=0 throughout.
REQ-033 Reset mid-debounce: Sw 2'b00->2'b01, assert rst_n=0 at edge 4 for 1 cycle -> Sw_LED stays 2'b00 until 2+4 edges after release.
